// File: rtl/irq_vector_fetch_if.sv
// Register-bus bundle between the vector fetch unit (master) and the VIC register bus (slave).
// The master drives request/address/write data and the slave returns grant and read data.
interface irq_vector_fetch_if;
  logic        bus_en;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_data_o;
  logic        bus_gnt;
  logic [31:0] bus_data_i;

  // Handshake: the master holds bus_en/bus_wr/bus_addr/bus_data_o stable while bus_en=1
  // until it samples bus_gnt=1 on a rising clock edge; that edge completes the beat. A
  // write completes in the grant cycle. For a read, bus_data_i is valid RD_LAT cycles
  // after the grant cycle and is only meaningful in that one cycle.
  modport master (
    output bus_en,
    output bus_wr,
    output bus_addr,
    output bus_data_o,
    input  bus_gnt,
    input  bus_data_i
  );

  modport slave (
    input  bus_en,
    input  bus_wr,
    input  bus_addr,
    input  bus_data_o,
    output bus_gnt,
    output bus_data_i
  );
endinterface

// File: rtl/irq_vector_fetch.sv
// CPU-side responder to a vectored interrupt controller: fetches the IRQ vector over the
// register bus, supplies a fixed FIQ vector, and writes the vector register on end-of-interrupt.
module irq_vector_fetch #(
    parameter logic [31:0] VIC_VECT_ADDR      = 32'hFFFF_F030,
    parameter logic [31:0] IRQ_DEFAULT_VECTOR = 32'h0000_0018,
    parameter logic [31:0] FIQ_VECTOR         = 32'h0000_001C,
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned RD_LAT             = 1,
    parameter int unsigned GNT_TIMEOUT        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   nVICIRQ,
    input  logic                   nVICFIQ,
    input  logic                   cpu_irq_mask,
    input  logic                   cpu_fiq_mask,
    input  logic                   cpu_ack,
    input  logic                   eoi_req,
    irq_vector_fetch_if.master     bus,
    output logic                   vect_valid,
    output logic [31:0]            vect_addr,
    output logic                   is_fiq,
    output logic                   eoi_done,
    output logic                   spurious,
    output logic                   bus_err,
    output logic [2:0]             state_dbg
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_IRQ_REQ  = 3'd1;
    localparam logic [2:0] S_IRQ_WAIT = 3'd2;
    localparam logic [2:0] S_VEC      = 3'd3;
    localparam logic [2:0] S_IN_IRQ   = 3'd4;
    localparam logic [2:0] S_EOI_REQ  = 3'd5;
    localparam logic [2:0] S_EOI_WAIT = 3'd6;

    localparam int unsigned TW = $clog2(GNT_TIMEOUT + 1);
    localparam int unsigned LW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(GNT_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = {TW{1'b1}};
    localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);
    localparam logic [LW-1:0] LAT_MAX  = {LW{1'b1}};

    logic [SYNC_STAGES-1:0] irq_sync;
    logic [SYNC_STAGES-1:0] fiq_sync;
    logic                   irq_s;
    logic                   fiq_s;

    logic [2:0]    state;
    logic [TW-1:0] tmo_cnt;
    logic [LW-1:0] lat_cnt;
    logic          ret_in_irq;
    logic          eoi_pend;
    logic          backoff;

    logic fiq_take;
    logic irq_take;
    logic tmo_hit;
    logic lat_hit;
    logic req_active;

    // Synchronizers idle at 1 so a freshly reset block sees no interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_sync <= '1;
            fiq_sync <= '1;
        end else begin
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], nVICIRQ};
            fiq_sync <= {fiq_sync[SYNC_STAGES-2:0], nVICFIQ};
        end
    end

    assign irq_s = ~irq_sync[SYNC_STAGES-1];
    assign fiq_s = ~fiq_sync[SYNC_STAGES-1];

    always_comb begin
        fiq_take = fiq_s && !cpu_fiq_mask && ((state == S_IDLE) || (state == S_IN_IRQ));
        irq_take = irq_s && !cpu_irq_mask;
        tmo_hit  = (tmo_cnt >= TMO_LAST);
        lat_hit  = (lat_cnt >= LAT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            tmo_cnt    <= '0;
            lat_cnt    <= '0;
            ret_in_irq <= 1'b0;
            eoi_pend   <= 1'b0;
            backoff    <= 1'b0;
            vect_addr  <= '0;
            is_fiq     <= 1'b0;
            spurious   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            spurious <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fiq_take) begin
                        state      <= S_VEC;
                        vect_addr  <= FIQ_VECTOR;
                        is_fiq     <= 1'b1;
                        ret_in_irq <= 1'b0;
                    end else if (irq_take) begin
                        state   <= S_IRQ_REQ;
                        tmo_cnt <= '0;
                    end
                end
                S_IRQ_REQ: begin
                    // A grant wins over a vanishing IRQ: once granted, the read is committed.
                    if (bus.bus_gnt) begin
                        state   <= S_IRQ_WAIT;
                        lat_cnt <= '0;
                    end else if (!irq_s) begin
                        state    <= S_IDLE;
                        spurious <= 1'b1;
                    end else if (tmo_hit) begin
                        state   <= S_IDLE;
                        bus_err <= 1'b1;
                    end else if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_IRQ_WAIT: begin
                    if (lat_hit) begin
                        state     <= S_VEC;
                        vect_addr <= (bus.bus_data_i == 32'h0) ? IRQ_DEFAULT_VECTOR : bus.bus_data_i;
                        is_fiq    <= 1'b0;
                    end else if (lat_cnt != LAT_MAX) begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_VEC: begin
                    // An EOI raised by the IRQ handler while a FIQ preempted it must survive.
                    if (is_fiq && ret_in_irq && eoi_req) begin
                        eoi_pend <= 1'b1;
                    end
                    if (cpu_ack) begin
                        is_fiq <= 1'b0;
                        state  <= (is_fiq && !ret_in_irq) ? S_IDLE : S_IN_IRQ;
                    end
                end
                S_IN_IRQ: begin
                    if (fiq_take) begin
                        state      <= S_VEC;
                        vect_addr  <= FIQ_VECTOR;
                        is_fiq     <= 1'b1;
                        ret_in_irq <= 1'b1;
                        if (eoi_req) begin
                            eoi_pend <= 1'b1;
                        end
                    end else if (eoi_req || eoi_pend) begin
                        state    <= S_EOI_REQ;
                        eoi_pend <= 1'b0;
                        tmo_cnt  <= '0;
                        backoff  <= 1'b0;
                    end
                end
                S_EOI_REQ: begin
                    // On timeout the request drops for one cycle and is retried; EOI is never lost.
                    if (backoff) begin
                        backoff <= 1'b0;
                        tmo_cnt <= '0;
                    end else if (bus.bus_gnt) begin
                        state <= S_EOI_WAIT;
                    end else if (tmo_hit) begin
                        bus_err <= 1'b1;
                        backoff <= 1'b1;
                        tmo_cnt <= '0;
                    end else if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_EOI_WAIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Bus outputs decode straight from state so an asynchronous reset drops them at once.
    always_comb begin
        req_active      = (state == S_IRQ_REQ) || ((state == S_EOI_REQ) && !backoff);
        bus.bus_en      = req_active;
        bus.bus_wr      = (state == S_EOI_REQ) && !backoff;
        bus.bus_addr    = req_active ? VIC_VECT_ADDR : 32'h0;
        bus.bus_data_o  = 32'h0;
        vect_valid      = (state == S_VEC);
        eoi_done        = (state == S_EOI_WAIT);
        state_dbg       = state;
    end

endmodule

// File: tb/tb_irq_vector_fetch.sv
// Directed-plus-random bench for irq_vector_fetch: a bus responder with programmable grant
// delay and read latency, a pulse/transfer monitor, and a vector model held in exp_q.
module tb_irq_vector_fetch;
  localparam logic [31:0] VIC_ADDR = 32'hFFFF_F030;
  localparam logic [31:0] DEF_VEC  = 32'h0000_0018;
  localparam logic [31:0] FIQ_VEC  = 32'h0000_001C;
  localparam int SYNC = 2;
  localparam int RLAT = 1;
  localparam int TMO  = 16;
  localparam logic [31:0] GARBAGE = 32'hA5A5_0F0F;

  localparam int SIG_VALID = 0;
  localparam int SIG_DONE  = 1;
  localparam int SIG_ERR   = 2;
  localparam int SIG_SPUR  = 3;
  localparam int SIG_EN    = 4;

  logic clk;
  logic rst;
  logic n_vic_irq;
  logic n_vic_fiq;
  logic cpu_irq_mask;
  logic cpu_fiq_mask;
  logic cpu_ack;
  logic eoi_req;
  logic vect_valid;
  logic [31:0] vect_addr;
  logic is_fiq;
  logic eoi_done;
  logic spurious;
  logic bus_err;
  logic [2:0] state_dbg;

  irq_vector_fetch_if bif ();

  irq_vector_fetch #(
    .VIC_VECT_ADDR(VIC_ADDR), .IRQ_DEFAULT_VECTOR(DEF_VEC), .FIQ_VECTOR(FIQ_VEC),
    .SYNC_STAGES(SYNC), .RD_LAT(RLAT), .GNT_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .nVICIRQ(n_vic_irq), .nVICFIQ(n_vic_fiq),
    .cpu_irq_mask(cpu_irq_mask), .cpu_fiq_mask(cpu_fiq_mask), .cpu_ack(cpu_ack),
    .eoi_req(eoi_req), .bus(bif.master), .vect_valid(vect_valid), .vect_addr(vect_addr),
    .is_fiq(is_fiq), .eoi_done(eoi_done), .spurious(spurious), .bus_err(bus_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus responder and monitor ----------------
  int gnt_delay = 0;
  bit gnt_block = 1'b0;
  logic [31:0] rd_value = 32'h0;
  int n_en = 0, n_rd = 0, n_wr = 0, n_spur = 0, n_err = 0, n_done = 0;
  logic [31:0] last_rd_addr = 32'h0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'hFFFF_FFFF;

  initial begin
    int pend_lat;
    int en_cnt;
    pend_lat = 0;
    en_cnt = 0;
    bif.bus_gnt = 1'b0;
    bif.bus_data_i = GARBAGE;
    forever begin
      @(negedge clk);
      if (pend_lat > 0) begin
        pend_lat--;
        bif.bus_data_i = (pend_lat == 0) ? rd_value : GARBAGE;
      end else begin
        bif.bus_data_i = GARBAGE;
      end
      if (bif.bus_en) begin
        bif.bus_gnt = !gnt_block && (en_cnt >= gnt_delay);
        en_cnt++;
        n_en++;
      end else begin
        bif.bus_gnt = 1'b0;
        en_cnt = 0;
      end
      if (bif.bus_en && bif.bus_gnt) begin
        if (bif.bus_wr) begin
          n_wr++;
          last_wr_addr = bif.bus_addr;
          last_wr_data = bif.bus_data_o;
        end else begin
          n_rd++;
          last_rd_addr = bif.bus_addr;
          pend_lat = RLAT;
        end
      end
      if (spurious) n_spur++;
      if (bus_err) n_err++;
      if (eoi_done) n_done++;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  function automatic logic [31:0] model_vector(input logic [31:0] fetched);
    return (fetched == 32'h0) ? DEF_VEC : fetched;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      SIG_VALID: return vect_valid;
      SIG_DONE:  return eoi_done;
      SIG_ERR:   return bus_err;
      SIG_SPUR:  return spurious;
      default:   return bif.bus_en;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input string tag, input int which, input int bound, output int cyc);
    cyc = 0;
    while (!sig_of(which) && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_seen"}, 32'(sig_of(which)), 32'd1);
  endtask

  // IRQ falls from a settled idle state; vector must appear after sync + take + grant wait + read latency.
  task automatic fetch_irq(input string tag, input logic [31:0] data, input int gd);
    int cyc;
    int rd0;
    rd_value = data;
    gnt_delay = gd;
    rd0 = n_rd;
    exp_q.push_back(model_vector(data));
    n_vic_irq = 1'b0;
    wait_for({tag, "_vec"}, SIG_VALID, 60, cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(SYNC + 2 + RLAT + gd));
    check({tag, "_vect_addr"}, vect_addr, exp_q.pop_front());
    check({tag, "_is_fiq"}, 32'(is_fiq), 32'd0);
    check({tag, "_rd_count"}, 32'(n_rd - rd0), 32'd1);
    check({tag, "_rd_addr"}, last_rd_addr, VIC_ADDR);
  endtask

  task automatic ack_vector(input string tag);
    logic [31:0] held;
    held = vect_addr;
    tick($urandom_range(0, 3));
    check({tag, "_held_valid"}, 32'(vect_valid), 32'd1);
    check({tag, "_held_addr"}, vect_addr, held);
    cpu_ack = 1'b1;
    tick(1);
    cpu_ack = 1'b0;
    check({tag, "_valid_drop"}, 32'(vect_valid), 32'd0);
  endtask

  task automatic pulse_eoi();
    eoi_req = 1'b1;
    tick(1);
    eoi_req = 1'b0;
  endtask

  task automatic expect_eoi(input string tag, input int wr0, input int done0);
    int cyc;
    wait_for({tag, "_eoi_done"}, SIG_DONE, 80, cyc);
    check({tag, "_wr_addr"}, last_wr_addr, VIC_ADDR);
    check({tag, "_wr_data"}, last_wr_data, 32'h0);
    tick(2);
    check({tag, "_wr_count"}, 32'(n_wr - wr0), 32'd1);
    check({tag, "_done_count"}, 32'(n_done - done0), 32'd1);
  endtask

  task automatic full_irq(input string tag, input logic [31:0] data, input int gd);
    int wr0;
    int done0;
    fetch_irq(tag, data, gd);
    ack_vector(tag);
    n_vic_irq = 1'b1;
    tick($urandom_range(0, 2));
    wr0 = n_wr;
    done0 = n_done;
    pulse_eoi();
    expect_eoi(tag, wr0, done0);
    tick(3);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int k;
    int en0, err0, spur0, wr0, done0, rd0;
    logic [31:0] d;

    rst = 1'b1;
    n_vic_irq = 1'b1;
    n_vic_fiq = 1'b1;
    cpu_irq_mask = 1'b0;
    cpu_fiq_mask = 1'b0;
    cpu_ack = 1'b0;
    eoi_req = 1'b0;
    tick(3);
    check("rst_bus_en", 32'(bif.bus_en), 32'd0);
    check("rst_bus_wr", 32'(bif.bus_wr), 32'd0);
    check("rst_bus_addr", bif.bus_addr, 32'h0);
    check("rst_bus_data_o", bif.bus_data_o, 32'h0);
    check("rst_vect", {29'h0, vect_valid, is_fiq, eoi_done}, 32'h0);
    check("rst_vect_addr", vect_addr, 32'h0);
    check("rst_pulses", {30'h0, spurious, bus_err}, 32'h0);
    rst = 1'b0;
    tick(4);
    check("idle_no_bus", 32'(n_en), 32'd0);

    // Basic fetch with immediate grant, then a default-vector fetch.
    full_irq("irq400", 32'h0000_0400, 0);
    full_irq("irq_zero", 32'h0, 0);

    // Random vectors and grant delays.
    for (int i = 0; i < 6; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      full_irq($sformatf("rnd%0d", i), d, $urandom_range(0, 4));
    end

    // IRQ and FIQ fall together: FIQ is served first without touching the bus.
    en0 = n_en;
    rd0 = n_rd;
    rd_value = 32'h0000_0800;
    gnt_delay = 0;
    exp_q.push_back(FIQ_VEC);
    n_vic_irq = 1'b0;
    n_vic_fiq = 1'b0;
    wait_for("both_fiq", SIG_VALID, 40, cyc);
    check("both_fiq_latency", 32'(cyc), 32'(SYNC + 1));
    check("both_fiq_addr", vect_addr, exp_q.pop_front());
    check("both_fiq_is_fiq", 32'(is_fiq), 32'd1);
    check("both_fiq_no_bus", 32'(n_en - en0), 32'd0);
    cpu_fiq_mask = 1'b1;
    ack_vector("both_fiq");
    exp_q.push_back(model_vector(rd_value));
    wait_for("both_irq", SIG_VALID, 40, cyc);
    check("both_irq_addr", vect_addr, exp_q.pop_front());
    check("both_irq_is_fiq", 32'(is_fiq), 32'd0);
    check("both_irq_rd_count", 32'(n_rd - rd0), 32'd1);
    ack_vector("both_irq");
    n_vic_irq = 1'b1;
    n_vic_fiq = 1'b1;
    wr0 = n_wr;
    done0 = n_done;
    pulse_eoi();
    expect_eoi("both", wr0, done0);
    cpu_fiq_mask = 1'b0;
    tick(3);

    // Grant never arrives: bus_err after the timeout window, no vector.
    gnt_block = 1'b1;
    en0 = n_en;
    err0 = n_err;
    spur0 = n_spur;
    n_vic_irq = 1'b0;
    wait_for("tmo_err", SIG_ERR, 60, cyc);
    cpu_irq_mask = 1'b1;
    check("tmo_bus_en_low", 32'(bif.bus_en), 32'd0);
    check("tmo_no_vec", 32'(vect_valid), 32'd0);
    check("tmo_en_cycles", 32'(n_en - en0), 32'(TMO));
    n_vic_irq = 1'b1;
    tick(4);
    check("tmo_err_count", 32'(n_err - err0), 32'd1);
    check("tmo_no_spur", 32'(n_spur - spur0), 32'd0);
    cpu_irq_mask = 1'b0;
    tick(2);

    // IRQ withdrawn while waiting for grant: spurious, no bus_err.
    err0 = n_err;
    spur0 = n_spur;
    n_vic_irq = 1'b0;
    wait_for("spur_en", SIG_EN, 20, cyc);
    k = 1;
    while (k < 5) begin
      tick(1);
      k++;
    end
    n_vic_irq = 1'b1;
    wait_for("spur_pulse", SIG_SPUR, 40, cyc);
    check("spur_bus_en_low", 32'(bif.bus_en), 32'd0);
    tick(3);
    check("spur_count", 32'(n_spur - spur0), 32'd1);
    check("spur_no_err", 32'(n_err - err0), 32'd0);
    check("spur_no_vec", 32'(vect_valid), 32'd0);
    gnt_block = 1'b0;
    tick(2);

    // FIQ preempts an IRQ handler; EOI raised during the FIQ vector is kept until return.
    fetch_irq("nest_irq", 32'h0000_1230, 1);
    ack_vector("nest_irq");
    n_vic_irq = 1'b1;
    tick(2);
    wr0 = n_wr;
    done0 = n_done;
    en0 = n_en;
    exp_q.push_back(FIQ_VEC);
    n_vic_fiq = 1'b0;
    wait_for("nest_fiq", SIG_VALID, 40, cyc);
    check("nest_fiq_latency", 32'(cyc), 32'(SYNC + 1));
    check("nest_fiq_addr", vect_addr, exp_q.pop_front());
    check("nest_fiq_is_fiq", 32'(is_fiq), 32'd1);
    pulse_eoi();
    tick(2);
    check("nest_no_early_wr", 32'(n_wr - wr0), 32'd0);
    check("nest_no_bus_in_fiq", 32'(n_en - en0), 32'd0);
    cpu_fiq_mask = 1'b1;
    ack_vector("nest_fiq");
    expect_eoi("nest", wr0, done0);
    n_vic_fiq = 1'b1;
    tick(4);
    cpu_fiq_mask = 1'b0;
    tick(2);

    // EOI write times out once and is retried until granted.
    fetch_irq("eoi_retry", 32'h0000_2000, 0);
    ack_vector("eoi_retry");
    n_vic_irq = 1'b1;
    tick(2);
    gnt_block = 1'b1;
    wr0 = n_wr;
    done0 = n_done;
    err0 = n_err;
    pulse_eoi();
    wait_for("eoi_tmo", SIG_ERR, 60, cyc);
    check("eoi_backoff_en", 32'(bif.bus_en), 32'd0);
    tick(1);
    check("eoi_retry_en", 32'(bif.bus_en), 32'd1);
    check("eoi_retry_wr", 32'(bif.bus_wr), 32'd1);
    gnt_block = 1'b0;
    expect_eoi("eoi_retry", wr0, done0);
    check("eoi_retry_err_count", 32'(n_err - err0), 32'd1);
    tick(2);

    // Reset in the middle of an EOI request, then normal service resumes.
    fetch_irq("rst_mid", 32'h0000_3450, 0);
    ack_vector("rst_mid");
    n_vic_irq = 1'b1;
    tick(2);
    gnt_block = 1'b1;
    pulse_eoi();
    wait_for("rst_mid_en", SIG_EN, 10, cyc);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_bus_en", 32'(bif.bus_en), 32'd0);
    check("rst_mid_bus_wr", 32'(bif.bus_wr), 32'd0);
    check("rst_mid_bus_addr", bif.bus_addr, 32'h0);
    check("rst_mid_vect_addr", vect_addr, 32'h0);
    check("rst_mid_flags", {29'h0, vect_valid, is_fiq, eoi_done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    gnt_block = 1'b0;
    tick(3);
    full_irq("post_rst", 32'h0000_5670, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
